// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: two one-entry slots (ALU, load) drained round-robin into a
// registered register-file write port. Writes to register 0 are dropped and counted.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              AValid,
    output logic              AReady,
    input  logic [ADDR_W-1:0] AAddr,
    input  logic [DATA_W-1:0] AData,
    input  logic              MValid,
    output logic              MReady,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MData,
    input  logic              Hold,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
    output logic              Idle,
    output logic [CNT_W-1:0]  DropCnt
);

    typedef enum logic {PRI_A, PRI_M} pri_t;

    pri_t              pri_q, pri_d;
    logic              a_full, m_full;
    logic [ADDR_W-1:0] a_addr, m_addr;
    logic [DATA_W-1:0] a_data, m_data;
    logic              grant_a, grant_m;
    logic              a_hs, m_hs;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) pri_q <= PRI_A;
        else        pri_q <= pri_d;
    end

    always_comb begin
        grant_a  = 1'b0;
        grant_m  = 1'b0;
        pri_d    = pri_q;
        sel_addr = a_addr;
        sel_data = a_data;
        if (!Hold) begin
            if (a_full && (!m_full || pri_q == PRI_A)) grant_a = 1'b1;
            else if (m_full)                           grant_m = 1'b1;
        end
        if (grant_a) pri_d = PRI_M;
        if (grant_m) begin
            pri_d    = PRI_A;
            sel_addr = m_addr;
            sel_data = m_data;
        end
    end

    // Ready depends only on registered state and Hold, never on Valid.
    assign AReady = !a_full || grant_a;
    assign MReady = !m_full || grant_m;
    assign a_hs   = AValid && AReady;
    assign m_hs   = MValid && MReady;
    assign Idle   = !a_full && !m_full && !WrEn;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_full <= 1'b0;
            a_addr <= '0;
            a_data <= '0;
            m_full <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
        end else begin
            if (a_hs) begin
                a_full <= 1'b1;
                a_addr <= AAddr;
                a_data <= AData;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end
            if (m_hs) begin
                m_full <= 1'b1;
                m_addr <= MAddr;
                m_data <= MData;
            end else if (grant_m) begin
                m_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            WrEn    <= 1'b0;
            Awr     <= '0;
            Din     <= '0;
            DropCnt <= '0;
        end else begin
            WrEn <= 1'b0;
            if (grant_a || grant_m) begin
                if (sel_addr != '0) begin
                    WrEn <= 1'b1;
                    Awr  <= sel_addr;
                    Din  <= sel_data;
                end else if (DropCnt != '1) begin
                    DropCnt <= DropCnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; expected values are hand-computed.
module tb_rf_wb_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        AValid, MValid, Hold;
    logic        AReady, MReady;
    logic [4:0]  AAddr, MAddr;
    logic [31:0] AData, MData;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn, Idle;
    logic [7:0]  DropCnt;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
        .MValid(MValid), .MReady(MReady), .MAddr(MAddr), .MData(MData),
        .Hold(Hold), .Awr(Awr), .Din(Din), .WrEn(WrEn), .Idle(Idle), .DropCnt(DropCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; state is settled afterwards.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    logic [4:0] exp_addr [6];
    logic       exp_ar [4];
    logic       exp_mr [5];
    int         ai, mi;
    logic       a_take, m_take;

    initial begin
        Rst_n = 1'b0; Hold = 1'b0;
        AValid = 1'b1; AAddr = 5'd3; AData = 32'h1111_1111;
        MValid = 1'b0; MAddr = '0; MData = '0;

        // 1. reset held three cycles with AValid asserted
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_wren", WrEn, 1'b0);
            chk("rst_awr", Awr, 5'd0);
            chk("rst_din", Din, 32'd0);
            chk("rst_aready", AReady, 1'b1);
            chk("rst_dropcnt", DropCnt, 8'd0);
            chk("rst_idle", Idle, 1'b1);
        end
        AValid = 1'b0;
        Rst_n  = 1'b1;
        tick();
        chk("post_rst_idle", Idle, 1'b1);

        // 2. single ALU write
        AValid = 1'b1; AAddr = 5'd5; AData = 32'hDEAD_BEEF;
        tick();
        AValid = 1'b0;
        chk("single_wren_n1", WrEn, 1'b0);
        tick();
        chk("single_wren", WrEn, 1'b1);
        chk("single_awr", Awr, 5'd5);
        chk("single_din", Din, 32'hDEAD_BEEF);
        tick();
        chk("single_wren_off", WrEn, 1'b0);

        // 3. back-to-back ALU writes to regs 1..4
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) begin
                AValid = 1'b1; AAddr = 5'(i); AData = 32'h100 + 32'(i);
            end else begin
                AValid = 1'b0;
            end
            #1;
            if (i <= 4) chk("b2b_aready", AReady, 1'b1);
            tick();
            if (i >= 2 && i <= 5) begin
                chk("b2b_wren", WrEn, 1'b1);
                chk("b2b_awr", Awr, 5'(i - 1));
                chk("b2b_din", Din, 32'h100 + 32'(i - 1));
            end
            if (i == 6) chk("b2b_wren_off", WrEn, 1'b0);
        end

        // reset restores pointer to A before contention
        Rst_n = 1'b0; #1;
        chk("rst2_wren", WrEn, 1'b0);
        Rst_n = 1'b1;
        tick();

        // 4. contention: A regs 1..3, M regs 11..13
        exp_addr = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
        exp_ar   = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_mr   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ai = 0; mi = 0;
        for (int c = 0; c <= 6; c++) begin
            AValid = (ai < 3); AAddr = 5'(1 + ai);  AData = 32'hA000_0000 | 32'(1 + ai);
            MValid = (mi < 3); MAddr = 5'(11 + mi); MData = 32'hB000_0000 | 32'(11 + mi);
            #1;
            if (AValid && c < 4) chk("cont_aready", AReady, exp_ar[c]);
            if (MValid && c < 5) chk("cont_mready", MReady, exp_mr[c]);
            a_take = AValid && AReady;
            m_take = MValid && MReady;
            tick();
            if (a_take) ai++;
            if (m_take) mi++;
            if (c >= 1) begin
                chk("cont_wren", WrEn, 1'b1);
                chk("cont_awr", Awr, exp_addr[c-1]);
                chk("cont_din", Din, ((exp_addr[c-1] >= 5'd11) ? 32'hB000_0000 : 32'hA000_0000)
                                     | 32'(exp_addr[c-1]));
            end
        end
        AValid = 1'b0; MValid = 1'b0;
        tick();
        chk("cont_wren_off", WrEn, 1'b0);

        // 5. write to register 0 is dropped
        AValid = 1'b1; AAddr = 5'd0; AData = 32'h1234_5678;
        tick();
        AValid = 1'b0;
        tick();
        chk("r0_wren", WrEn, 1'b0);
        chk("r0_dropcnt", DropCnt, 8'd1);
        chk("r0_awr", Awr, 5'd13);
        chk("r0_din", Din, 32'hB000_000D);

        // 6a. hold with both slots full, then drain (pointer is at M)
        Hold = 1'b1;
        AValid = 1'b1; AAddr = 5'd7; AData = 32'h0000_0777;
        MValid = 1'b1; MAddr = 5'd8; MData = 32'h0000_0888;
        tick();
        AValid = 1'b0; MValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("hold_aready", AReady, 1'b0);
            chk("hold_mready", MReady, 1'b0);
            chk("hold_idle", Idle, 1'b0);
            tick();
            chk("hold_wren", WrEn, 1'b0);
        end
        Hold = 1'b0;
        tick();
        chk("drain1_wren", WrEn, 1'b1);
        chk("drain1_awr", Awr, 5'd8);
        chk("drain1_din", Din, 32'h0000_0888);
        tick();
        chk("drain2_wren", WrEn, 1'b1);
        chk("drain2_awr", Awr, 5'd7);
        chk("drain2_din", Din, 32'h0000_0777);
        tick();
        chk("drain_idle", Idle, 1'b1);

        // 6b. reset while both slots are full
        Hold = 1'b1;
        AValid = 1'b1; AAddr = 5'd9;  AData = 32'h0000_0999;
        MValid = 1'b1; MAddr = 5'd10; MData = 32'h0000_0AAA;
        tick();
        AValid = 1'b0; MValid = 1'b0;
        chk("pre_rst_idle", Idle, 1'b0);
        Rst_n = 1'b0; #1;
        chk("midrst_idle", Idle, 1'b1);
        chk("midrst_aready", AReady, 1'b1);
        chk("midrst_dropcnt", DropCnt, 8'd0);
        #1;
        Rst_n = 1'b1;
        Hold  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midrst_wren", WrEn, 1'b0);
            chk("midrst_idle_after", Idle, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
